sipo_router: RTL and testbench

- Serial-in/parallel-out front end of the PMU.
- A 1-bit stream is shifted into a 128-bit register, then transferred on command to one of three registered parallel destinations:
  - key register (scan-chain key load),
  - 32-bit memory write word,
  - 128-bit AES data block.
- The AES block can alternatively be assembled from 32-bit words supplied by memory.

---
 rtl/sipo_router_pkg.sv | 35 +++
 rtl/sipo_shreg.sv | 24 ++
 rtl/sipo_router.sv | 79 +++++++
 tb/tb_sipo_router.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_router_pkg.sv
// Shared PMU definitions: datapath widths, transfer instruction encodings and decode.
package sipo_router_pkg;

  localparam int unsigned PMU_DATA_W = 128;
  localparam int unsigned PMU_MEM_W  = 32;
  localparam int unsigned INSTR_W    = 4;

  localparam logic [INSTR_W-1:0] INSTR_KEY     = 4'h0;
  localparam logic [INSTR_W-1:0] INSTR_MEM     = 4'h1;
  localparam logic [INSTR_W-1:0] INSTR_AES     = 4'h2;
  localparam logic [INSTR_W-1:0] INSTR_AES_MEM = 4'h3;

  // One-hot transfer target selected by an instruction.
  typedef struct packed {
    logic key;
    logic mem;
    logic aes;
    logic aes_mem;
  } xfer_sel_t;

  // Reserved encodings (instruction[3:2] != 0) select nothing.
  function automatic xfer_sel_t decode_instr(input logic [INSTR_W-1:0] instr);
    xfer_sel_t sel;
    sel = '0;
    case (instr)
      INSTR_KEY:     sel.key     = 1'b1;
      INSTR_MEM:     sel.mem     = 1'b1;
      INSTR_AES:     sel.aes     = 1'b1;
      INSTR_AES_MEM: sel.aes_mem = 1'b1;
      default:       sel         = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in shift register; bits enter at the MSB and move toward the LSB.
module sipo_shreg
  import sipo_router_pkg::*;
#(
  parameter int unsigned W = PMU_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         hold,
  input  logic         data_i,
  output logic [W-1:0] q
);

  // After W shifts, the k-th received bit sits in q[k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en && !hold) begin
      q <= {data_i, q[W-1:1]};
    end
  end

endmodule

// File: rtl/sipo_router.sv
// PMU serial front end: collects a serial stream and routes it, on a send edge,
// to the key, memory-word or AES-block output registers.
module sipo_router
  import sipo_router_pkg::*;
#(
  parameter int unsigned DATA_W = PMU_DATA_W,
  parameter int unsigned MEM_W  = PMU_MEM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               send,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               data_i,
  input  logic [MEM_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]  aes_data_o,
  output logic [DATA_W-1:0]  key_data_o,
  output logic [MEM_W-1:0]   mem_data_o
);

  logic              send_d;
  logic              send_edge_c;
  logic [DATA_W-1:0] shift_q;
  xfer_sel_t         sel_c;
  logic [DATA_W-1:0] aes_next_c;
  logic [DATA_W-1:0] key_next_c;
  logic [MEM_W-1:0]  mem_next_c;

  assign send_edge_c = send & ~send_d;

  // A send edge freezes the shift register for that cycle and drops data_i.
  sipo_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .hold   (send_edge_c),
    .data_i (data_i),
    .q      (shift_q)
  );

  // Next-value mux; untargeted outputs keep their contents.
  always_comb begin
    sel_c      = '0;
    aes_next_c = aes_data_o;
    key_next_c = key_data_o;
    mem_next_c = mem_data_o;
    if (send_edge_c) begin
      sel_c = decode_instr(instruction);
    end
    if (sel_c.key) begin
      key_next_c = shift_q;
    end
    if (sel_c.mem) begin
      mem_next_c = shift_q[DATA_W-1 -: MEM_W];
    end
    if (sel_c.aes) begin
      aes_next_c = shift_q;
    end else if (sel_c.aes_mem) begin
      aes_next_c = {mem_data_i, aes_data_o[DATA_W-1:MEM_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_d     <= 1'b0;
      aes_data_o <= '0;
      key_data_o <= '0;
      mem_data_o <= '0;
    end else begin
      send_d     <= send;
      aes_data_o <= aes_next_c;
      key_data_o <= key_next_c;
      mem_data_o <= mem_next_c;
    end
  end

endmodule

// File: tb/tb_sipo_router.sv
// Scoreboard bench for sipo_router: stimulus queues expected outputs, a negedge monitor checks them.
module tb_sipo_router;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         send;
  logic [3:0]   instruction;
  logic         data_i;
  logic [31:0]  mem_data_i;
  logic [127:0] aes_data_o;
  logic [127:0] key_data_o;
  logic [31:0]  mem_data_o;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] aes;
    logic [31:0]  mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [127:0] K  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [31:0]  DB = 32'hdeadbeef;

  always #5 clk = ~clk;

  sipo_router dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .send        (send),
    .instruction (instruction),
    .data_i      (data_i),
    .mem_data_i  (mem_data_i),
    .aes_data_o  (aes_data_o),
    .key_data_o  (key_data_o),
    .mem_data_o  (mem_data_o)
  );

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_all(input string name, input logic [127:0] key,
                           input logic [127:0] aes, input logic [31:0] mem);
    check128({name, ".key"}, key_data_o, key);
    check128({name, ".aes"}, aes_data_o, aes);
    check128({name, ".mem"}, {96'h0, mem_data_o}, {96'h0, mem});
  endtask

  task automatic push(input string name, input logic [127:0] key,
                      input logic [127:0] aes, input logic [31:0] mem);
    exp_t e;
    e.name = name;
    e.key  = key;
    e.aes  = aes;
    e.mem  = mem;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable at the falling edge after each transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all(e.name, e.key, e.aes, e.mem);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      en     = 1'b1;
      data_i = v[i];
      tick();
    end
    en     = 1'b0;
    data_i = 1'b0;
  endtask

  // Raise send for `hold` cycles; the edge cycle carries instr/mdi and en_edge.
  task automatic pulse_send(input logic [3:0] instr, input logic [31:0] mdi,
                            input int hold, input logic en_edge);
    instruction = instr;
    mem_data_i  = mdi;
    send        = 1'b1;
    en          = en_edge;
    data_i      = 1'b1;
    tick();
    en          = 1'b0;
    data_i      = 1'b0;
    instruction = 4'hf;
    mem_data_i  = 32'hffff_0000;
    for (int i = 1; i < hold; i++) begin
      instruction = 4'h3;
      tick();
    end
    send        = 1'b0;
    instruction = 4'hf;
  endtask

  initial begin
    logic [127:0] a1, a2, a3, a4, a5;
    rst = 1'b1; en = 1'b0; send = 1'b0; instruction = 4'h0;
    data_i = 1'b0; mem_data_i = 32'h0;
    #2;
    check_all("reset", 128'h0, 128'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Key load, then AES direct from the same shift contents.
    shift_bits(K, 128);
    pulse_send(4'h0, 32'h0, 1, 1'b0);
    push("key_load", K, 128'h0, 32'h0);
    tick();
    pulse_send(4'h2, 32'h0, 1, 1'b0);
    push("aes_direct", K, K, 32'h0);
    tick();

    // Memory word: last 32 bits shifted.
    shift_bits({96'h0, DB}, 32);
    pulse_send(4'h1, 32'h0, 1, 1'b0);
    push("mem_word", K, K, DB);
    tick();

    // AES assembly from four memory words.
    a1 = {32'h11111111, 96'h0123456789abcdef01234567};
    a2 = {32'h22222222, 32'h11111111, 64'h0123456789abcdef};
    a3 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h01234567};
    a4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    pulse_send(4'h3, 32'h11111111, 1, 1'b0); push("aes_mem1", K, a1, DB); tick();
    pulse_send(4'h3, 32'h22222222, 1, 1'b0); push("aes_mem2", K, a2, DB); tick();
    pulse_send(4'h3, 32'h33333333, 1, 1'b0); push("aes_mem3", K, a3, DB); tick();
    pulse_send(4'h3, 32'h44444444, 1, 1'b0); push("aes_mem4", K, a4, DB); tick();

    // Held send with en=1 on the edge: one word shift, shift register untouched.
    a5 = {32'ha5a5a5a5, 32'h44444444, 32'h33333333, 32'h22222222};
    pulse_send(4'h3, 32'ha5a5a5a5, 5, 1'b1);
    push("held_send", K, a5, DB);
    tick();
    push("held_no_rearm", K, a5, DB);
    tick();
    pulse_send(4'h0, 32'h0, 1, 1'b0);
    push("edge_priority", {DB, 96'h0123456789abcdef01234567}, a5, DB);
    tick();

    // Reserved encodings leave everything alone.
    shift_bits(128'h5, 3);
    pulse_send(4'b0100, 32'h12345678, 1, 1'b0);
    push("reserved_4", {DB, 96'h0123456789abcdef01234567}, a5, DB);
    tick();
    pulse_send(4'b1010, 32'h12345678, 1, 1'b0);
    push("reserved_a", {DB, 96'h0123456789abcdef01234567}, a5, DB);
    tick();
    tick();

    // Reset mid-stream clears outputs combinationally and discards the partial shift.
    en = 1'b1; data_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    check_all("async_reset", 128'h0, 128'h0, 32'h0);
    en = 1'b0; data_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    pulse_send(4'h0, 32'h0, 1, 1'b0);
    push("post_reset_key", 128'h0, 128'h0, 32'h0);
    tick();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
